// File: rtl/axi_lite_sram_rsp.sv
// axi_lite_sram_rsp: AXI-lite read responder in front of a synchronous SRAM,
// one outstanding read, fixed AR-to-R latency, SLVERR for out-of-window or misaligned reads.
module axi_lite_sram_rsp #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int                    DEPTH      = 1024,
   parameter int                    LATENCY    = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       arvalid_i,
   output logic                       arready_o,
   input  logic [ADDR_WIDTH-1:0]      araddr_i,
   output logic                       rvalid_o,
   input  logic                       rready_i,
   output logic [DATA_WIDTH-1:0]      rdata_o,
   output logic [1:0]                 rresp_o,
   output logic                       mem_en_o,
   output logic [$clog2(DEPTH)-1:0]   mem_addr_o,
   input  logic [DATA_WIDTH-1:0]      mem_rdata_i
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_B = $clog2(BYTES);
   localparam int MAW   = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0]   SPAN  = (ADDR_WIDTH+1)'(DEPTH * BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN = ADDR_WIDTH'(BYTES - 1);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  cap_q, cap_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [ADDR_WIDTH-1:0] off;
   logic                  in_range, hs;
   // Range test uses a subtraction guarded by araddr_i >= BASE_ADDR, so no sum can overflow into the window.
   assign off        = araddr_i - BASE_ADDR;
   assign in_range   = (araddr_i >= BASE_ADDR) && ({1'b0, off} < SPAN) && ((araddr_i & ALIGN) == '0);
   assign arready_o  = state_q == IDLE;
   assign rvalid_o   = state_q == RESP;
   assign hs         = arvalid_i & arready_o;
   assign mem_en_o   = hs & in_range & rst_i;
   assign mem_addr_o = MAW'(off >> OFF_B);
   assign rdata_o    = rvalid_o ? data_q : '0;
   assign rresp_o    = rresp_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = 1'b0;
      rresp_d = rresp_q;
      data_d  = cap_q ? (rresp_q[1] ? '0 : mem_rdata_i) : data_q;
      case (state_q)
         IDLE: if (hs) begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
            cap_d   = 1'b1;
            rresp_d = in_range ? 2'b00 : 2'b10;
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_d == 4'd0) ? RESP : WAIT;
         end
         RESP:    state_d = rready_i ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cap_q   <= 1'b0;
         data_q  <= '0;
         rresp_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         data_q  <= data_d;
         rresp_q <= rresp_d;
      end
   end
endmodule

// File: doc/axi_lite_sram_rsp.md
AXI_LITE_SRAM_RSP -- requirements
Module: axi_lite_sram_rsp

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: AXI-lite address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: read data width.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000: first byte address served.
REQ-004 The block SHALL have parameter DEPTH, default 1024: number of DATA_WIDTH words served.
REQ-005 The block SHALL have parameter LATENCY, default 3, legal range 2..15: cycles from AR handshake to first rvalid.
REQ-006 The block SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
REQ-008 The block SHALL have port arvalid_i, input, 1: read address valid.
REQ-009 The block SHALL have port arready_o, output, 1: read address accept.
REQ-010 The block SHALL have port araddr_i, input, ADDR_WIDTH: read byte address.
REQ-011 The block SHALL have port rvalid_o, output, 1: read response valid.
REQ-012 The block SHALL have port rready_i, input, 1: response accept.
REQ-013 The block SHALL have port rdata_o, output, DATA_WIDTH: read data.
REQ-014 The block SHALL have port rresp_o, output, 2: 2'b00 OKAY, 2'b10 SLVERR.
REQ-015 The block SHALL have port mem_en_o, output, 1: synchronous SRAM read enable.
REQ-016 The block SHALL have port mem_addr_o, output, clog2(DEPTH): SRAM word index.
REQ-017 The block SHALL have port mem_rdata_i, input, DATA_WIDTH: SRAM data, valid the cycle after mem_en_o.

Function
REQ-018 The block SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE, with one transaction outstanding at a time.
REQ-019 In IDLE, arready_o SHALL be 1; in WAIT and RESP, arready_o SHALL be 0.
REQ-020 An AR handshake (arvalid_i & arready_o in cycle T) SHALL latch araddr_i, move to WAIT, and load the latency counter with LATENCY-1.
REQ-021 Address check: an access SHALL be in range iff BASE_ADDR <= araddr_i < BASE_ADDR+DEPTH*(DATA_WIDTH/8) and the byte-offset bits are zero; otherwise it SHALL be an error.
REQ-022 mem_en_o SHALL equal arvalid_i & arready_o & in-range (combinational).
REQ-023 mem_addr_o SHALL equal (araddr_i-BASE_ADDR)>>log2(DATA_WIDTH/8) (combinational).
REQ-024 mem_en_o SHALL be 0 for error accesses.
REQ-025 In cycle T+1, mem_rdata_i SHALL be captured into the response data register; for an error access, the register SHALL be loaded with 0.
REQ-026 The response code register SHALL be loaded with OKAY or SLVERR at the handshake edge.
REQ-027 WAIT SHALL decrement the counter each cycle and move to RESP when the counter is 0, so rvalid_o first rises in cycle T+LATENCY.
REQ-028 In RESP, rvalid_o SHALL be 1, and rdata_o/rresp_o SHALL hold stable until rready_i is sampled 1.
REQ-029 On rvalid_o & rready_i, the FSM SHALL return to IDLE; arready_o rises the next cycle, and there is no same-cycle AR turnaround.
REQ-030 rready_i SHALL be ignored outside RESP.
REQ-031 arvalid_i and araddr_i SHALL be ignored outside IDLE.
REQ-032 A back-pressured response (rready_i=0 for N cycles) SHALL be held indefinitely with no data change.
REQ-033 An address of all ones SHALL wrap-safely decode as an error, with no arithmetic overflow into range.
REQ-034 rdata_o SHALL equal 0 whenever rvalid_o=0.

Reset
REQ-035 While rst_i=0, the block SHALL immediately force the state to IDLE, counter=0, rvalid_o=0, arready_o=1, rdata_o=0, rresp_o=2'b00, and mem_en_o=0, independent of clk_i.
REQ-036 Reset asserted mid-WAIT or mid-RESP SHALL abandon the transaction, with no response issued after release.
REQ-037 The first AR handshake SHALL be accepted on the first rising edge after rst_i deasserts.

Verification
REQ-038 Basic read: mem word 5=32'hDEAD_BEEF, AR 0x8000_0014 at cycle 10, rready_i=1 -> mem_en_o=1 and mem_addr_o=5 at cycle 10; rvalid_o=1 at cycle 13 with rdata_o=32'hDEAD_BEEF and rresp_o=2'b00; arready_o=1 at cycle 14.
REQ-039 Back-pressure: same read with rready_i held 0 for 5 cycles after rvalid_o -> rvalid_o/rdata_o stable for 6 cycles, a concurrent arvalid_i is not accepted, and the handshake completes on the first rready_i=1.
REQ-040 Errors: AR 0x8000_0002 (misaligned), 0x7FFF_FFFC, 0x8000_1000 (one past end), and 0xFFFF_FFFC -> mem_en_o=0, rresp_o=2'b10, rdata_o=0, same latency.
REQ-041 Boundary: AR 0x8000_0FFC -> mem_addr_o=1023 and rresp_o=OKAY.
REQ-042 Reset mid-operation: rst_i=0 one cycle after handshake -> rvalid_o=0 within the reset cycle; after release no rvalid_o occurs without a new AR, and a new AR is served normally.
REQ-043 Back-to-back with LATENCY=2: two reads issued with arvalid_i held high -> second handshake is exactly one cycle after the first R handshake, and response order and data are correct.
